// File: rtl/dp_types_pkg.sv
// Shared datapath types for the branch-prediction loop: predictor states,
// the update function, the branch-queue entry and the resolver FSM enum.
package dp_types_pkg;

  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b10,
    TH = 2'b11
  } branch_pred_state_t;

  typedef enum logic {
    BRES_RUN     = 1'b0,
    BRES_RECOVER = 1'b1
  } br_res_state_t;

  // Address fields are stored at this width; narrower WORD_W is zero-extended.
  localparam int BQ_ADDR_W = 32;

  typedef struct packed {
    logic                   taken;
    branch_pred_state_t     state;
    logic [BQ_ADDR_W-1:0]   pc4;
    logic [BQ_ADDR_W-1:0]   baddr;
  } bq_entry_t;

  function automatic branch_pred_state_t bpred_update(input branch_pred_state_t state,
                                                      input logic taken);
    branch_pred_state_t nxt;
    nxt = NH;
    case (state)
      NH: nxt = taken ? NS : NH;
      NS: nxt = taken ? TS : NH;
      TS: nxt = taken ? TH : NS;
      TH: nxt = taken ? TH : TS;
      default: nxt = NH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bq_fifo.sv
// In-order queue of predicted branches. Head is read combinationally;
// clear has priority over push/pop and empties the queue in one cycle.
module bq_fifo
  import dp_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  bq_entry_t        wdata,
  output bq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  bq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // A full-queue push only happens alongside a pop, so the slot being
  // overwritten is the head that is leaving this cycle.
  always_ff @(posedge CLK) begin
    if (do_push && !clear && !RST) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: compares execute outcomes with queued predictions and emits
// registered mispredict redirects and predictor training. Option: BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import dp_types_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               pred_push,
  input  logic               pred_taken,
  input  branch_pred_state_t pred_state,
  input  logic [WORD_W-1:0]  pred_pc4,
  input  logic [WORD_W-1:0]  pred_baddr,
  output logic               pred_full,
  input  logic               res_valid,
  input  logic               res_taken,
  input  logic               flush,
  output logic               mispredict,
  output logic [WORD_W-1:0]  redirect_pc,
  output logic               bp_loadEN,
  output branch_pred_state_t bp_load_state,
  output logic               res_err,
  output br_res_state_t      dbg_state
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  br_res_state_t    state_q;
  br_res_state_t    state_d;
  bq_entry_t        head;
  bq_entry_t        wdata;
  logic [CNT_W-1:0] count;
  logic             q_full;
  logic             q_empty;
  logic             run;
  logic             resolve;
  logic             err;
  logic             miss;
  logic             push_ok;
  logic             clear;

  // Handshake: fetch may push only while pred_full is low (a full queue still
  // takes a push when a resolve pops the head that cycle); res_valid is a
  // one-cycle strobe with no back-pressure, ignored during RECOVER.
  assign run     = (state_q == BRES_RUN);
  assign resolve = res_valid && run && !q_empty;
  assign err     = res_valid && run && q_empty;
  assign miss    = resolve && (head.taken != res_taken);
  assign push_ok = pred_push && run && (!q_full || resolve);
  assign clear   = flush || miss;

  assign pred_full = q_full || (state_q == BRES_RECOVER);
  assign dbg_state = state_q;

  always_comb begin
    wdata       = '0;
    wdata.taken = pred_taken;
    wdata.state = pred_state;
    wdata.pc4   = BQ_ADDR_W'(pred_pc4);
    wdata.baddr = BQ_ADDR_W'(pred_baddr);
  end

  bq_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_bq (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_ok),
    .pop   (resolve),
    .clear (clear),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= BRES_RUN;
    else     state_q <= state_d;
  end

  // RECOVER always lasts one cycle; only a mispredict enters it.
  always_comb begin
    state_d = BRES_RUN;
    if (miss) state_d = BRES_RECOVER;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      bp_loadEN     <= 1'b0;
      bp_load_state <= NH;
      res_err       <= 1'b0;
    end else begin
      mispredict <= miss;
      bp_loadEN  <= resolve;
      res_err    <= err;
      if (miss)
        redirect_pc <= res_taken ? WORD_W'(head.baddr) : WORD_W'(head.pc4);
      if (resolve)
        bp_load_state <= bpred_update(head.state, res_taken);
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (resolve && !miss) hit_cnt  <= hit_cnt + 32'd1;
      if (miss)             miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (DEPTH=4, WORD_W=32) with hand-computed
// expectations checked by immediate assertions.
module tb_branch_resolver;
  import dp_types_pkg::*;

  logic               CLK;
  logic               RST;
  logic               pred_push;
  logic               pred_taken;
  branch_pred_state_t pred_state;
  logic [31:0]        pred_pc4;
  logic [31:0]        pred_baddr;
  logic               pred_full;
  logic               res_valid;
  logic               res_taken;
  logic               flush;
  logic               mispredict;
  logic [31:0]        redirect_pc;
  logic               bp_loadEN;
  branch_pred_state_t bp_load_state;
  logic               res_err;
  br_res_state_t      dbg_state;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  branch_resolver #(.DEPTH(4), .WORD_W(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .pred_push     (pred_push),
    .pred_taken    (pred_taken),
    .pred_state    (pred_state),
    .pred_pc4      (pred_pc4),
    .pred_baddr    (pred_baddr),
    .pred_full     (pred_full),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .flush         (flush),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .bp_loadEN     (bp_loadEN),
    .bp_load_state (bp_load_state),
    .res_err       (res_err),
    .dbg_state     (dbg_state)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic idle();
    pred_push  = 1'b0;
    pred_taken = 1'b0;
    pred_state = NH;
    pred_pc4   = '0;
    pred_baddr = '0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic t, input branch_pred_state_t s,
                      input logic [31:0] pc4, input logic [31:0] ba);
    pred_push  = 1'b1;
    pred_taken = t;
    pred_state = s;
    pred_pc4   = pc4;
    pred_baddr = ba;
  endtask

  task automatic resolve(input logic t);
    res_valid = 1'b1;
    res_taken = t;
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // reset state
    chk("rst_mispredict", 64'(mispredict), 64'(1'b0));
    chk("rst_redirect",   64'(redirect_pc), 64'(32'h0));
    chk("rst_loaden",     64'(bp_loadEN), 64'(1'b0));
    chk("rst_loadstate",  64'(bp_load_state), 64'(NH));
    chk("rst_err",        64'(res_err), 64'(1'b0));
    chk("rst_full",       64'(pred_full), 64'(1'b0));
    chk("rst_fsm",        64'(dbg_state), 64'(BRES_RUN));

    // correct taken prediction: TS trains to TH
    push(1'b1, TS, 32'h104, 32'h200);
    tick();
    idle(); resolve(1'b1);
    tick();
    chk("t1_loaden",    64'(bp_loadEN), 64'(1'b1));
    chk("t1_loadstate", 64'(bp_load_state), 64'(TH));
    chk("t1_misp",      64'(mispredict), 64'(1'b0));
    chk("t1_err",       64'(res_err), 64'(1'b0));
    idle();
    tick();
    chk("t1_loaden_pulse", 64'(bp_loadEN), 64'(1'b0));
    chk("t1_state_hold",   64'(bp_load_state), 64'(TH));

    // mispredict: predicted not-taken, actually taken; same-cycle push is wrong-path
    push(1'b0, NS, 32'h108, 32'h300);
    tick();
    idle(); resolve(1'b1); push(1'b1, TH, 32'h700, 32'h800);
    tick();
    chk("t2_misp",      64'(mispredict), 64'(1'b1));
    chk("t2_redirect",  64'(redirect_pc), 64'(32'h300));
    chk("t2_loadstate", 64'(bp_load_state), 64'(TS));
    chk("t2_loaden",    64'(bp_loadEN), 64'(1'b1));
    chk("t2_full_recov", 64'(pred_full), 64'(1'b1));
    chk("t2_fsm_recov",  64'(dbg_state), 64'(BRES_RECOVER));
    // RECOVER cycle: push and res_valid ignored
    idle(); resolve(1'b0); push(1'b0, NH, 32'h900, 32'h904);
    tick();
    chk("t2_misp_pulse",   64'(mispredict), 64'(1'b0));
    chk("t2_recov_noerr",  64'(res_err), 64'(1'b0));
    chk("t2_recov_noload", 64'(bp_loadEN), 64'(1'b0));
    chk("t2_full_back",    64'(pred_full), 64'(1'b0));
    chk("t2_redirect_hold", 64'(redirect_pc), 64'(32'h300));
    // queue must be empty now
    idle(); resolve(1'b1);
    tick();
    chk("t2_empty_err",    64'(res_err), 64'(1'b1));
    chk("t2_empty_noload", 64'(bp_loadEN), 64'(1'b0));
    chk("t2_empty_nomisp", 64'(mispredict), 64'(1'b0));
    idle();
    tick();
    chk("t2_err_pulse", 64'(res_err), 64'(1'b0));

    // fill the queue, then push with and without a resolve
    push(1'b0, NH, 32'h10, 32'h20); tick();
    push(1'b0, NS, 32'h14, 32'h24); tick();
    push(1'b0, TS, 32'h18, 32'h28); tick();
    chk("t3_not_full_3", 64'(pred_full), 64'(1'b0));
    push(1'b0, TH, 32'h1c, 32'h2c); tick();
    chk("t3_full_4", 64'(pred_full), 64'(1'b1));
    idle(); push(1'b1, TH, 32'h500, 32'h600); resolve(1'b0);
    tick();
    chk("t3_pr_loaden",    64'(bp_loadEN), 64'(1'b1));
    chk("t3_pr_loadstate", 64'(bp_load_state), 64'(NH));
    chk("t3_pr_misp",      64'(mispredict), 64'(1'b0));
    chk("t3_pr_full",      64'(pred_full), 64'(1'b1));
    idle(); push(1'b0, NH, 32'hA00, 32'hA04);
    tick();
    chk("t3_refused_full", 64'(pred_full), 64'(1'b1));
    chk("t3_refused_noload", 64'(bp_loadEN), 64'(1'b0));
    idle(); resolve(1'b0);
    tick();
    chk("t3_d1_state", 64'(bp_load_state), 64'(NH));
    chk("t3_d1_full",  64'(pred_full), 64'(1'b0));
    tick();
    chk("t3_d2_state", 64'(bp_load_state), 64'(NS));
    tick();
    chk("t3_d3_state", 64'(bp_load_state), 64'(TS));
    chk("t3_d3_misp",  64'(mispredict), 64'(1'b0));
    tick();
    chk("t3_d4_misp",     64'(mispredict), 64'(1'b1));
    chk("t3_d4_redirect", 64'(redirect_pc), 64'(32'h500));
    chk("t3_d4_state",    64'(bp_load_state), 64'(TS));
    idle();
    tick();
    resolve(1'b1);
    tick();
    chk("t3_refused_gone", 64'(res_err), 64'(1'b1));
    idle();
    tick();

    // flush together with a resolution and a push
    push(1'b1, NS, 32'h40, 32'h44); tick();
    push(1'b1, TH, 32'h48, 32'h4c); tick();
    push(1'b0, NH, 32'h50, 32'h54); tick();
    idle(); flush = 1'b1; resolve(1'b1); push(1'b1, TS, 32'h60, 32'h64);
    tick();
    chk("t4_loaden",    64'(bp_loadEN), 64'(1'b1));
    chk("t4_loadstate", 64'(bp_load_state), 64'(TS));
    chk("t4_misp",      64'(mispredict), 64'(1'b0));
    chk("t4_full",      64'(pred_full), 64'(1'b0));
    idle(); resolve(1'b1);
    tick();
    chk("t4_cleared_err", 64'(res_err), 64'(1'b1));
    chk("t4_cleared_noload", 64'(bp_loadEN), 64'(1'b0));
    idle();
    tick();

`ifdef BRANCH_RESOLVER_STATS_EN
    chk("st_hit",  64'(hit_cnt), 64'(32'd6));
    chk("st_miss", 64'(miss_cnt), 64'(32'd2));
`endif

    // reset mid-operation discards entries and suppresses pulses
    push(1'b1, NH, 32'h70, 32'h74);
    tick();
    idle(); RST = 1'b1; resolve(1'b0);
    tick();
    idle(); RST = 1'b0;
    chk("t5_misp",      64'(mispredict), 64'(1'b0));
    chk("t5_loaden",    64'(bp_loadEN), 64'(1'b0));
    chk("t5_loadstate", 64'(bp_load_state), 64'(NH));
    chk("t5_redirect",  64'(redirect_pc), 64'(32'h0));
    chk("t5_err",       64'(res_err), 64'(1'b0));
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("t5_hit_rst",  64'(hit_cnt), 64'(32'd0));
    chk("t5_miss_rst", 64'(miss_cnt), 64'(32'd0));
`endif
    resolve(1'b1);
    tick();
    chk("t5_discarded", 64'(res_err), 64'(1'b1));
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
